// File: rtl/sram_pack_pkg.sv
// Shared constants, state encoding and byte-enable helper for the
// sample packer that fills the 128-bit x 8000-word sample SRAM.
package sram_pack_pkg;

   localparam int LANE_W = 32;
   localparam int LANES  = 4;
   localparam int WORD_W = 128;
   localparam int BE_W   = 16;
   localparam int ADDR_W = 13;
   localparam int DEPTH  = 8000;
   localparam int CNT_W  = 3;

   typedef enum logic {
      ACCUM = 1'b0,
      WRITE = 1'b1
   } state_e;

   // One 4-bit enable group per filled lane, low lanes first.
   function automatic logic [BE_W-1:0] lane_be(
      input logic [CNT_W-1:0] n
   );
      logic [BE_W-1:0] be;
      be = '0;
      for (int k = 0; k < LANES; k++) begin
         if (k < int'(n)) be[k*4 +: 4] = 4'hF;
      end
      return be;
   endfunction

endpackage

// File: rtl/sram_ring_ptr.sv
// Modulo-DEPTH SRAM word pointer with sync clear and sticky wrap flag.
// Ports: clk, reset_n, clr, inc in; ptr, wrapped out (registered).
module sram_ring_ptr
   import sram_pack_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clr,
   input  logic              inc,
   output logic [ADDR_W-1:0] ptr,
   output logic              wrapped
);

   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              wrapped_q, wrapped_d;
   logic              last;

   assign last = (ptr_q == ADDR_W'(DEPTH - 1));

   always_comb begin
      ptr_d     = ptr_q;
      wrapped_d = wrapped_q;
      if (clr) begin
         ptr_d     = '0;
         wrapped_d = 1'b0;
      end else if (inc) begin
         ptr_d     = last ? '0 : ptr_q + 1'b1;
         wrapped_d = wrapped_q | last;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr_q     <= '0;
         wrapped_q <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign ptr     = ptr_q;
   assign wrapped = wrapped_q;

endmodule

// File: rtl/sram_sample_packer.sv
// Packs four 32-bit stream samples per 128-bit word, writes them to a
// circular SRAM buffer over Avalon-MM; partial-word flush and clear.
// Ports: s_* sample stream, flush/clear controls, m_* SRAM master,
// wr_ptr/wrapped/flush_done status. All outputs registered.
module sram_sample_packer
   import sram_pack_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_valid,
   input  logic [LANE_W-1:0] s_data,
   output logic              s_ready,
   input  logic              flush,
   input  logic              clear,
   output logic [ADDR_W-1:0] m_address,
   output logic [BE_W-1:0]   m_byteenable,
   output logic              m_chipselect,
   output logic              m_write,
   output logic [WORD_W-1:0] m_writedata,
   output logic              m_clken,
   output logic [ADDR_W-1:0] wr_ptr,
   output logic              wrapped,
   output logic              flush_done
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_n;
   logic [WORD_W-1:0] acc_q, acc_d, acc_n;
   logic              pend_q, pend_d;
   logic              wfl_q, wfl_d;
   logic              rdy_q, rdy_d;
   logic              wr_q, wr_d;
   logic              cs_q, cs_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              clken_q;
   logic              accept, fl_eff;
   logic              ptr_inc, ptr_clr;

   assign accept = s_valid & rdy_q;
   assign fl_eff = flush | pend_q;

   sram_ring_ptr u_ptr (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (ptr_clr),
      .inc     (ptr_inc),
      .ptr     (wr_ptr),
      .wrapped (wrapped)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      pend_d  = pend_q;
      wfl_d   = wfl_q;
      rdy_d   = 1'b0;
      wr_d    = 1'b0;
      cs_d    = 1'b0;
      addr_d  = '0;
      be_d    = '0;
      wdata_d = '0;
      done_d  = 1'b0;
      ptr_inc = 1'b0;
      ptr_clr = 1'b0;
      cnt_n   = cnt_q;
      acc_n   = acc_q;

      // Pack first so a same-cycle flush sees the new sample.
      if (accept) begin
         for (int k = 0; k < LANES; k++) begin
            if (cnt_q == CNT_W'(k))
               acc_n[k*LANE_W +: LANE_W] = s_data;
         end
         cnt_n = cnt_q + 1'b1;
      end

      unique case (state_q)
         ACCUM: begin
            acc_d = acc_n;
            cnt_d = cnt_n;
            if (cnt_n == CNT_W'(LANES) ||
                (fl_eff && cnt_n != '0)) begin
               state_d = WRITE;
               wr_d    = 1'b1;
               cs_d    = 1'b1;
               addr_d  = wr_ptr;
               be_d    = lane_be(cnt_n);
               wdata_d = acc_n;
               wfl_d   = fl_eff;
               pend_d  = 1'b0;
            end else begin
               rdy_d = 1'b1;
               if (fl_eff) begin
                  done_d = 1'b1;
                  pend_d = 1'b0;
               end
            end
         end
         WRITE: begin
            state_d = ACCUM;
            rdy_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            ptr_inc = 1'b1;
            done_d  = wfl_q;
            wfl_d   = 1'b0;
            // Served after this write, never merged into it.
            if (flush) pend_d = 1'b1;
         end
      endcase

      if (clear) begin
         state_d = ACCUM;
         rdy_d   = 1'b1;
         wr_d    = 1'b0;
         cs_d    = 1'b0;
         addr_d  = '0;
         be_d    = '0;
         wdata_d = '0;
         acc_d   = '0;
         cnt_d   = '0;
         pend_d  = 1'b0;
         wfl_d   = 1'b0;
         done_d  = 1'b0;
         ptr_inc = 1'b0;
         ptr_clr = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
         acc_q   <= '0;
         pend_q  <= 1'b0;
         wfl_q   <= 1'b0;
         rdy_q   <= 1'b0;
         wr_q    <= 1'b0;
         cs_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         clken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         pend_q  <= pend_d;
         wfl_q   <= wfl_d;
         rdy_q   <= rdy_d;
         wr_q    <= wr_d;
         cs_q    <= cs_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         clken_q <= 1'b1;
      end
   end

   assign s_ready      = rdy_q;
   assign m_write      = wr_q;
   assign m_chipselect = cs_q;
   assign m_address    = addr_q;
   assign m_byteenable = be_q;
   assign m_writedata  = wdata_q;
   assign flush_done   = done_q;
   assign m_clken      = clken_q;

endmodule

// File: tb/tb_sram_sample_packer.sv
// Directed self-checking bench for sram_sample_packer:
// full/partial writes, flush, clear, wrap-around, async reset.
module tb_sram_sample_packer;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         s_valid;
   logic [31:0]  s_data;
   logic         s_ready;
   logic         flush;
   logic         clear;
   logic [12:0]  m_address;
   logic [15:0]  m_byteenable;
   logic         m_chipselect;
   logic         m_write;
   logic [127:0] m_writedata;
   logic         m_clken;
   logic [12:0]  wr_ptr;
   logic         wrapped;
   logic         flush_done;

   int checks = 0;
   int errors = 0;

   sram_sample_packer dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_ready      (s_ready),
      .flush        (flush),
      .clear        (clear),
      .m_address    (m_address),
      .m_byteenable (m_byteenable),
      .m_chipselect (m_chipselect),
      .m_write      (m_write),
      .m_writedata  (m_writedata),
      .m_clken      (m_clken),
      .wr_ptr       (wr_ptr),
      .wrapped      (wrapped),
      .flush_done   (flush_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [127:0] got,
                      input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d);
      s_valid = 1'b1;
      s_data  = d;
      tick();
      s_valid = 1'b0;
   endtask

   int          sent, writes, cyc;
   logic [12:0] last_addr;
   logic [127:0] last_data;

   initial begin
      reset_n = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      flush   = 1'b0;
      clear   = 1'b0;
      repeat (3) tick();
      chk("rst_ready", s_ready, 0);
      chk("rst_clken", m_clken, 0);
      chk("rst_write", m_write, 0);
      chk("rst_ptr", wr_ptr, 0);
      chk("rst_wrap", wrapped, 0);
      chk("rst_done", flush_done, 0);
      reset_n = 1'b1;
      tick();
      chk("rel_ready", s_ready, 1);
      chk("rel_clken", m_clken, 1);

      // full word
      push(32'h11111111);
      push(32'h22222222);
      push(32'h33333333);
      push(32'h44444444);
      chk("full_write", m_write, 1);
      chk("full_cs", m_chipselect, 1);
      chk("full_addr", m_address, 0);
      chk("full_data", m_writedata,
          128'h44444444_33333333_22222222_11111111);
      chk("full_be", m_byteenable, 16'hFFFF);
      chk("full_rdy_lo", s_ready, 0);
      tick();
      chk("full_wr_end", m_write, 0);
      chk("full_rdy_hi", s_ready, 1);
      chk("full_ptr", wr_ptr, 1);

      // partial flush
      push(32'hAAAAAAAA);
      push(32'hBBBBBBBB);
      push(32'hCCCCCCCC);
      chk("part_nowr", m_write, 0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("part_write", m_write, 1);
      chk("part_addr", m_address, 1);
      chk("part_be", m_byteenable, 16'h0FFF);
      chk("part_data", m_writedata,
          128'h00000000_CCCCCCCC_BBBBBBBB_AAAAAAAA);
      chk("part_done_lo", flush_done, 0);
      tick();
      chk("part_done", flush_done, 1);
      chk("part_ptr", wr_ptr, 2);
      tick();
      chk("part_done_end", flush_done, 0);

      // empty flush
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("empty_nowr", m_write, 0);
      chk("empty_done", flush_done, 1);
      tick();
      chk("empty_done_end", flush_done, 0);
      chk("empty_ptr", wr_ptr, 2);

      // flush during WRITE, then one sample
      push(32'h1);
      push(32'h2);
      push(32'h3);
      push(32'h4);
      chk("fw_write", m_write, 1);
      chk("fw_addr", m_address, 2);
      flush   = 1'b1;
      s_valid = 1'b1;
      s_data  = 32'h55555555;
      tick();
      flush = 1'b0;
      chk("fw_full_be", m_write, 0);
      chk("fw_nodone", flush_done, 0);
      chk("fw_rdy", s_ready, 1);
      tick();
      s_valid = 1'b0;
      chk("fw_pwrite", m_write, 1);
      chk("fw_paddr", m_address, 3);
      chk("fw_pbe", m_byteenable, 16'h000F);
      chk("fw_pdata", m_writedata, 128'h55555555);
      tick();
      chk("fw_done", flush_done, 1);
      chk("fw_ptr", wr_ptr, 4);

      // clear discards partial word
      push(32'h77);
      push(32'h88);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_nowr", m_write, 0);
      chk("clr_ptr", wr_ptr, 0);
      chk("clr_wrap", wrapped, 0);
      chk("clr_rdy", s_ready, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("clr_empty_nowr", m_write, 0);
      chk("clr_empty_done", flush_done, 1);
      tick();

      // 8000 words streamed back to back
      sent   = 0;
      writes = 0;
      cyc    = 0;
      last_addr = '0;
      last_data = '0;
      while (writes < 8000 && cyc < 45000) begin
         s_valid = (sent < 32000);
         s_data  = sent;
         if (s_valid && s_ready) sent++;
         tick();
         cyc++;
         if (m_write) begin
            writes++;
            last_addr = m_address;
            last_data = m_writedata;
         end
      end
      s_valid = 1'b0;
      chk("wrap_writes", writes, 8000);
      chk("wrap_cycles", cyc, 39999);
      chk("wrap_last_addr", last_addr, 7999);
      chk("wrap_last_data", last_data,
          {32'd31999, 32'd31998, 32'd31997, 32'd31996});
      chk("wrap_pre", wrapped, 0);
      tick();
      chk("wrap_ptr", wr_ptr, 0);
      chk("wrap_flag", wrapped, 1);
      push(32'hD1);
      push(32'hD2);
      push(32'hD3);
      push(32'hD4);
      chk("w8001_write", m_write, 1);
      chk("w8001_addr", m_address, 0);
      tick();
      chk("w8001_ptr", wr_ptr, 1);
      chk("w8001_wrap", wrapped, 1);

      // async reset in the middle of a write
      push(32'hE1);
      push(32'hE2);
      push(32'hE3);
      push(32'hE4);
      chk("ar_write", m_write, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_write_drop", m_write, 0);
      chk("ar_cs", m_chipselect, 0);
      chk("ar_rdy", s_ready, 0);
      chk("ar_ptr", wr_ptr, 0);
      chk("ar_wrap", wrapped, 0);
      chk("ar_clken", m_clken, 0);
      chk("ar_data", m_writedata, 0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("ar_rel_rdy", s_ready, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("ar_lost_nowr", m_write, 0);
      chk("ar_lost_done", flush_done, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
